// File: rtl/nonce_search_ctrl_if.sv
// Job, hash-pipeline and result signals of the nonce search controller.
// slave = controller side, master = job source / hash core / result sink side.
interface nonce_search_ctrl_if #(
  parameter int NONCE_W = 32
);
  logic               job_valid;
  logic               job_ready;
  logic [127:0]       job_data;
  logic [7:0]         job_difficulty;
  logic               abort;
  logic               hash_i_valid;
  logic [127:0]       hash_i_data;
  logic               hash_o_valid;
  logic [127:0]       hash_o_data;
  logic               res_valid;
  logic               res_ready;
  logic               res_found;
  logic [NONCE_W-1:0] res_nonce;
  logic [127:0]       res_hash;
  logic               busy;
  logic               err;

  modport slave (
    input  job_valid, job_data, job_difficulty, abort, hash_o_valid, hash_o_data, res_ready,
    output job_ready, hash_i_valid, hash_i_data, res_valid, res_found, res_nonce, res_hash,
           busy, err
  );

  modport master (
    output job_valid, job_data, job_difficulty, abort, hash_o_valid, hash_o_data, res_ready,
    input  job_ready, hash_i_valid, hash_i_data, res_valid, res_found, res_nonce, res_hash,
           busy, err
  );
endinterface

// File: rtl/nonce_search_ctrl.sv
// Drives a fixed-latency, in-order hash pipeline across the nonce space of one job and
// reports the first nonce whose hash has at least `difficulty` leading zero bits.
module nonce_search_ctrl #(
  parameter int NONCE_W      = 32,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nonce_search_ctrl_if.slave    bus
);
  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, REPORT} state_t;

  state_t               r_state;
  logic [127:0]         r_tmpl;
  logic [7:0]           r_diff;
  logic [NONCE_W-1:0]   r_nonce;
  logic [NONCE_W-1:0]   r_fifo [MAX_INFLIGHT];
  logic [PW-1:0]        r_wp, r_rp;
  logic [CW-1:0]        r_cnt;
  logic                 r_hit, r_abort, r_err;
  logic [NONCE_W-1:0]   r_hit_nonce;
  logic [127:0]         r_hit_hash;
  logic                 r_res_valid, r_res_found;
  logic [NONCE_W-1:0]   r_res_nonce;
  logic [127:0]         r_res_hash;

  logic                 w_issue, w_pop, w_qual, w_hit_now, w_last, w_found;
  logic [7:0]           w_lz;
  logic [NONCE_W-1:0]   w_pop_nonce, w_fnonce;
  logic [127:0]         w_fhash, w_hdata;
  logic [CW-1:0]        w_cnt_nx;

  assign w_issue     = (r_state == ISSUE) && (r_cnt < CW'(MAX_INFLIGHT)) && !r_hit;
  assign w_pop       = bus.hash_o_valid && (r_cnt != '0);
  assign w_pop_nonce = r_fifo[r_rp];
  assign w_last      = (r_nonce == '1);
  assign w_cnt_nx    = r_cnt + CW'(w_issue) - CW'(w_pop);

  // Highest set bit wins; an all-zero hash keeps the default of 128.
  always_comb begin
    w_lz = 8'd128;
    for (int i = 0; i < 128; i++)
      if (bus.hash_o_data[i]) w_lz = 8'(127 - i);
  end

  assign w_qual    = (w_lz >= r_diff);
  assign w_hit_now = w_pop && w_qual && !r_hit && ((r_state == ISSUE) || (r_state == DRAIN));

  // The final drain cycle may itself carry the first hit, so bypass the hit registers.
  assign w_found  = !(r_abort || bus.abort) && (r_hit || w_hit_now);
  assign w_fnonce = r_hit ? r_hit_nonce : w_pop_nonce;
  assign w_fhash  = r_hit ? r_hit_hash  : bus.hash_o_data;

  always_comb begin
    w_hdata                = r_tmpl;
    w_hdata[NONCE_W-1:0]   = r_nonce;
  end

  assign bus.job_ready    = (r_state == IDLE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.hash_i_valid = w_issue;
  assign bus.hash_i_data  = w_hdata;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_found    = r_res_found;
  assign bus.res_nonce    = r_res_nonce;
  assign bus.res_hash     = r_res_hash;
  assign bus.err          = r_err;

  always_ff @(posedge clk)
    if (w_issue) r_fifo[r_wp] <= r_nonce;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tmpl      <= '0;
      r_diff      <= '0;
      r_nonce     <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_hit       <= 1'b0;
      r_abort     <= 1'b0;
      r_err       <= 1'b0;
      r_hit_nonce <= '0;
      r_hit_hash  <= '0;
      r_res_valid <= 1'b0;
      r_res_found <= 1'b0;
      r_res_nonce <= '0;
      r_res_hash  <= '0;
    end else begin
      if (bus.hash_o_valid && (r_cnt == '0)) r_err <= 1'b1;
      if (w_issue) begin
        r_wp    <= r_wp + 1'b1;
        r_nonce <= r_nonce + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= w_cnt_nx;
      if (w_hit_now) begin
        r_hit       <= 1'b1;
        r_hit_nonce <= w_pop_nonce;
        r_hit_hash  <= bus.hash_o_data;
      end
      case (r_state)
        IDLE: if (bus.job_valid) begin
          r_tmpl  <= bus.job_data;
          r_diff  <= (bus.job_difficulty > 8'd128) ? 8'd128 : bus.job_difficulty;
          r_nonce <= '0;
          r_hit   <= 1'b0;
          r_abort <= 1'b0;
          r_state <= ISSUE;
        end
        ISSUE: begin
          if (bus.abort) begin
            r_abort <= 1'b1;
            r_state <= DRAIN;
          end else if (w_hit_now || (w_issue && w_last)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.abort) r_abort <= 1'b1;
          if (w_cnt_nx == '0) begin
            r_state     <= REPORT;
            r_res_valid <= 1'b1;
            r_res_found <= w_found;
            r_res_nonce <= w_found ? w_fnonce : '0;
            r_res_hash  <= w_found ? w_fhash  : '0;
          end
        end
        REPORT: if (bus.res_ready) begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_res_found <= 1'b0;
          r_res_nonce <= '0;
          r_res_hash  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: fixed-latency hash core stand-in, a queue-based job model
// compared against the DUT every cycle, and literal per-job result expectations.
module tb_nonce_search_ctrl;
  localparam int NW   = 5;
  localparam int MAXI = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nonce_search_ctrl_if #(.NONCE_W(NW)) bus();
  nonce_search_ctrl #(.NONCE_W(NW), .MAX_INFLIGHT(MAXI)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // hash core stand-in
  typedef struct { int due; logic [127:0] h; } ret_t;
  ret_t         core_q[$];
  int           lat = 5;
  logic         hit_en = 1'b0;
  int           hit_nonce = 0;
  logic [127:0] hit_val = '0;
  logic         stray = 1'b0;
  int           n_issue = 0;
  int           max_infl = 0;

  // job model: phase 0 idle, 1 issuing, 2 draining, 3 reporting
  int           m_phase, m_diff, m_nonce, m_hn, m_rn;
  logic         m_hit, m_abort, m_err, m_rv, m_rf;
  logic [127:0] m_hh, m_tmpl, m_rh;
  int           mq[$];

  localparam logic [127:0] TMPL  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] ONES  = '1;
  localparam logic [127:0] H00FF = 128'h00FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int lzc(input logic [127:0] h);
    int n = 0;
    while (n < 128 && !h[127-n]) n++;
    return n;
  endfunction

  function automatic logic exp_issue();
    return (m_phase == 1) && (mq.size() < MAXI) && !m_hit;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_diff = 0; m_nonce = 0; m_hn = 0; m_rn = 0;
    m_hit = 1'b0; m_abort = 1'b0; m_err = 1'b0; m_rv = 1'b0; m_rf = 1'b0;
    m_hh = '0; m_tmpl = '0; m_rh = '0;
    mq.delete();
  endtask

  // Advance the model over the cycle whose inputs are still applied.
  task automatic model_step();
    logic iss, hit_now, last;
    int   n;
    iss = exp_issue(); hit_now = 1'b0; last = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (bus.hash_o_valid) begin
      if (mq.size() == 0) m_err = 1'b1;
      else begin
        n = mq.pop_front();
        if ((m_phase == 1 || m_phase == 2) && !m_hit && lzc(bus.hash_o_data) >= m_diff) begin
          m_hit = 1'b1; m_hn = n; m_hh = bus.hash_o_data; hit_now = 1'b1;
        end
      end
    end
    if (iss) begin
      mq.push_back(m_nonce);
      last = (m_nonce == (1 << NW) - 1);
      m_nonce++;
    end
    case (m_phase)
      0: if (bus.job_valid) begin
        m_tmpl  = bus.job_data;
        m_diff  = (bus.job_difficulty > 8'd128) ? 128 : int'(bus.job_difficulty);
        m_nonce = 0; m_hit = 1'b0; m_abort = 1'b0; m_phase = 1;
      end
      1: if (bus.abort) begin
        m_abort = 1'b1; m_phase = 2;
      end else if (hit_now || last) m_phase = 2;
      2: begin
        if (bus.abort) m_abort = 1'b1;
        if (mq.size() == 0) begin
          m_phase = 3; m_rv = 1'b1; m_rf = m_hit && !m_abort;
          m_rn = m_rf ? m_hn : 0;
          m_rh = m_rf ? m_hh : '0;
        end
      end
      default: if (bus.res_ready) begin
        m_phase = 0; m_rv = 1'b0; m_rf = 1'b0; m_rn = 0; m_rh = '0;
      end
    endcase
  endtask

  task automatic compare();
    chkb("job_ready", bus.job_ready, m_phase == 0);
    chkb("busy", bus.busy, m_phase != 0);
    chkb("err", bus.err, m_err);
    chkb("hash_i_valid", bus.hash_i_valid, exp_issue());
    if (exp_issue()) chk("hash_i_data", bus.hash_i_data, {m_tmpl[127:NW], NW'(m_nonce)});
    chkb("res_valid", bus.res_valid, m_rv);
    chkb("res_found", bus.res_found, m_rf);
    chki("res_nonce", int'(bus.res_nonce), m_rn);
    chk("res_hash", bus.res_hash, m_rh);
  endtask

  task automatic core_step();
    logic [127:0] h;
    ret_t         r;
    if (bus.hash_i_valid) begin
      n_issue++;
      h = ONES;
      if (hit_en && int'(bus.hash_i_data[NW-1:0]) == hit_nonce) h = hit_val;
      r.due = cyc + lat; r.h = h;
      core_q.push_back(r);
    end
    if (core_q.size() > max_infl) max_infl = core_q.size();
    bus.hash_o_valid = stray; bus.hash_o_data = ONES; stray = 1'b0;
    if (core_q.size() > 0 && core_q[0].due == cyc) begin
      r = core_q.pop_front();
      bus.hash_o_valid = 1'b1; bus.hash_o_data = r.h;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
    compare();
    core_step();
  endtask

  // Offer a job, optionally keep job_valid up (with a poisoned difficulty) for `hold`
  // extra cycles, optionally pulse abort, and wait for the report.
  task automatic run_job(input logic [7:0] df, input int hold, input int abort_at,
                         output logic f, output int n, output logic [127:0] h);
    bus.job_valid = 1'b1; bus.job_data = TMPL; bus.job_difficulty = df;
    n_issue = 0; max_infl = 0;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (i > hold) bus.job_valid = 1'b0;
      else bus.job_difficulty = 8'd0;
      bus.abort = (i == abort_at);
      if (bus.res_valid) break;
    end
    bus.abort = 1'b0;
    chkb("report_seen", bus.res_valid, 1'b1);
    f = bus.res_found; n = int'(bus.res_nonce); h = bus.res_hash;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic         f;
    int           n;
    logic [127:0] h;
    model_reset();
    bus.job_valid = 1'b0; bus.job_data = '0; bus.job_difficulty = '0; bus.abort = 1'b0;
    bus.hash_o_valid = 1'b0; bus.hash_o_data = '0; bus.res_ready = 1'b1;
    repeat (3) tick();
    chkb("rst_job_ready", bus.job_ready, 1'b1);
    chkb("rst_hash_i_valid", bus.hash_i_valid, 1'b0);
    chkb("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    tick();

    // hit on nonce 7 at difficulty 8; job_valid held on with difficulty 0 must be ignored
    lat = 5; hit_en = 1'b1; hit_nonce = 7; hit_val = H00FF;
    run_job(8'd8, 2, 0, f, n, h);
    chkb("t1_found", f, 1'b1);
    chki("t1_nonce", n, 7);
    chk("t1_hash", h, H00FF);
    chki("t1_issues", n_issue, 13);
    chki("t1_inflight_at_report", core_q.size(), 0);
    repeat (2) tick();

    // difficulty 0: nonce 0 wins, later qualifying returns ignored
    hit_en = 1'b0;
    run_job(8'd0, 0, 0, f, n, h);
    chkb("t2_found", f, 1'b1);
    chki("t2_nonce", n, 0);
    chk("t2_hash", h, ONES);
    chki("t2_issues", n_issue, 6);
    repeat (2) tick();

    // exhaustion of the 5-bit nonce space, no wrap
    run_job(8'd1, 0, 0, f, n, h);
    chkb("t3_found", f, 1'b0);
    chki("t3_nonce", n, 0);
    chk("t3_hash", h, '0);
    chki("t3_issues", n_issue, 32);
    repeat (2) tick();

    // long latency: in-flight limit stalls issue
    lat = 40;
    run_job(8'd1, 0, 0, f, n, h);
    chkb("t4_found", f, 1'b0);
    chki("t4_issues", n_issue, 32);
    chki("t4_max_inflight", max_infl, 16);
    repeat (2) tick();

    // abort while a hit on nonce 1 is in flight; result held under backpressure
    lat = 5; hit_en = 1'b1; hit_nonce = 1; hit_val = '0;
    bus.res_ready = 1'b0;
    run_job(8'd8, 0, 3, f, n, h);
    chkb("t5_found", f, 1'b0);
    chki("t5_nonce", n, 0);
    chk("t5_hash", h, '0);
    chki("t5_issues", n_issue, 3);
    repeat (10) tick();
    chkb("t5_hold_valid", bus.res_valid, 1'b1);
    chkb("t5_hold_found", bus.res_found, 1'b0);
    bus.res_ready = 1'b1;
    repeat (2) tick();
    chkb("t5_idle_ready", bus.job_ready, 1'b1);

    // difficulty above 128 clamps to 128: only an all-zero hash qualifies
    hit_nonce = 2; hit_val = '0;
    run_job(8'd200, 0, 0, f, n, h);
    chkb("t6_found", f, 1'b1);
    chki("t6_nonce", n, 2);
    chk("t6_hash", h, '0);
    repeat (2) tick();

    // stray return in IDLE sets sticky err
    hit_en = 1'b0;
    stray = 1'b1;
    repeat (2) tick();
    chkb("t7_err_set", bus.err, 1'b1);
    run_job(8'd0, 0, 0, f, n, h);
    chkb("t7_err_sticky", bus.err, 1'b1);
    chki("t7_nonce", n, 0);
    repeat (2) tick();

    // reset mid-ISSUE, then late returns raise err again
    bus.job_valid = 1'b1; bus.job_data = TMPL; bus.job_difficulty = 8'd1;
    tick();
    bus.job_valid = 1'b0;
    repeat (2) tick();
    chkb("t8_busy_before_rst", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkb("t8_rst_job_ready", bus.job_ready, 1'b1);
    chkb("t8_rst_hash_i_valid", bus.hash_i_valid, 1'b0);
    chkb("t8_rst_res_valid", bus.res_valid, 1'b0);
    chkb("t8_rst_busy", bus.busy, 1'b0);
    chkb("t8_rst_err", bus.err, 1'b0);
    repeat (8) tick();
    chkb("t8_late_err", bus.err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
